// File: rtl/sec_a2b_serial_pkg.sv
// sec_a2b_serial_pkg: shared state encoding and derived randomness widths for the serial A2B converter
package sec_a2b_serial_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;
  function automatic int rand_and(input int n);
    return n * (n - 1) / 2;
  endfunction
  function automatic int rand_ref(input int k, input int n);
    return k * (n - 1);
  endfunction
endpackage

// File: rtl/sec_a2b_serial_and.sv
// sec_and_n: combinational 1-bit ISW AND over N_SHARES Boolean shares
module sec_and_n
  import sec_a2b_serial_pkg::*;
#(
  parameter int N_SHARES = 3,
  parameter int RAND_AND = rand_and(N_SHARES)
) (
  input  logic [N_SHARES-1:0] i_x,
  input  logic [N_SHARES-1:0] i_y,
  input  logic [RAND_AND-1:0] i_r,
  output logic [N_SHARES-1:0] o_z
);
  logic [N_SHARES-1:0] w_m [N_SHARES];
  for (genvar i = 0; i < N_SHARES; i++) begin : g_r
    for (genvar j = 0; j < N_SHARES; j++) begin : g_c
      if (j > i) begin : g_u
        assign w_m[i][j] = i_r[i*N_SHARES - i*(i+1)/2 + j - i - 1];
      end else if (j < i) begin : g_l
        // mask first, then add the second cross term, so no unmasked pair sum appears
        assign w_m[i][j] = (i_r[j*N_SHARES - j*(j+1)/2 + i - j - 1] ^ (i_x[j] & i_y[i])) ^ (i_x[i] & i_y[j]);
      end else begin : g_d
        assign w_m[i][j] = i_x[i] & i_y[i];
      end
    end
    assign o_z[i] = ^w_m[i];
  end
endmodule

// File: rtl/sec_a2b_serial.sv
// sec_a2b_serial: bit-serial masked ripple-carry A2B conversion, one SecAnd reused for every addition
module sec_a2b_serial
  import sec_a2b_serial_pkg::*;
#(
  parameter  int K_WIDTH  = 32,
  parameter  int N_SHARES = 3,
  localparam int RAND_AND = rand_and(N_SHARES),
  localparam int RAND_REF = rand_ref(K_WIDTH, N_SHARES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        i_dvld,
  input  logic                        i_rvld,
  input  logic [K_WIDTH*N_SHARES-1:0] i_a,
  input  logic [RAND_REF-1:0]         i_n_ref,
  input  logic [RAND_AND-1:0]         i_n_and,
  output logic [K_WIDTH*N_SHARES-1:0] o_b,
  output logic                        o_dvld,
  output logic                        o_busy
);
  localparam int IW = $clog2(N_SHARES);
  localparam int BW = $clog2(K_WIDTH);
  state_t                             r_state;
  logic [N_SHARES-1:0][K_WIDTH-1:0]   r_a, r_acc, r_y, r_b;
  logic [N_SHARES-1:0]                r_c;
  logic [IW-1:0]                      r_idx;
  logic [BW-1:0]                      r_bit;
  logic                               r_dvld, r_busy;
  logic [K_WIDTH-1:0]                 w_src;
  logic [N_SHARES-1:0][K_WIDTH-1:0]   w_ref, w_acc_n;
  logic [N_SHARES-1:0]                w_x, w_y, w_sum, w_and;
  assign o_b    = r_b;
  assign o_dvld = r_dvld;
  assign o_busy = r_busy;
  always_comb begin
    w_src    = r_state == IDLE ? i_a[K_WIDTH-1:0] : r_a[r_idx];
    w_ref[0] = w_src;
    for (int j = 1; j < N_SHARES; j++) begin
      w_ref[j] = i_n_ref[(j-1)*K_WIDTH +: K_WIDTH];
      w_ref[0] = w_ref[0] ^ w_ref[j];
    end
    for (int s = 0; s < N_SHARES; s++) begin
      w_x[s]     = r_acc[s][0];
      w_y[s]     = r_y[s][0];
      w_sum[s]   = w_x[s] ^ w_y[s] ^ r_c[s];
      w_acc_n[s] = {w_sum[s], r_acc[s][K_WIDTH-1:1]};
    end
  end
  // majority(x,y,c) = ((x^c)&(y^c))^c keeps the only nonlinear step inside SecAnd
  sec_and_n #(.N_SHARES(N_SHARES), .RAND_AND(RAND_AND)) u_and (
    .i_x (w_x ^ r_c),
    .i_y (w_y ^ r_c),
    .i_r (i_n_and),
    .o_z (w_and)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_idx   <= '0;
      r_bit   <= '0;
      r_dvld  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (i_rvld) begin
      case (r_state)
        IDLE: if (i_dvld) begin
          r_a     <= i_a;
          r_acc   <= w_ref;
          r_idx   <= IW'(1);
          r_busy  <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: begin
          r_y     <= w_ref;
          r_c     <= '0;
          r_bit   <= '0;
          r_state <= ADD;
        end
        ADD: begin
          r_acc <= w_acc_n;
          for (int s = 0; s < N_SHARES; s++) r_y[s] <= r_y[s] >> 1;
          r_c   <= w_and ^ r_c;
          r_bit <= r_bit + BW'(1);
          if (r_bit == BW'(K_WIDTH - 1)) begin
            if (r_idx == IW'(N_SHARES - 1)) begin
              r_b     <= w_acc_n;
              r_dvld  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= LOAD;
            end
          end
        end
        DONE: begin
          r_dvld  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sec_a2b_serial.sv
// tb_sec_a2b_serial: randomized bench with a cycle-level behavioural model of the A2B converter
module tb_sec_a2b_serial;
  localparam int K = 32, N = 3, RR = K * (N - 1), RA = N * (N - 1) / 2, LAT = 1 + (N - 1) * (K + 1);
  logic           clk_i = 1'b0, rst_ni = 1'b0, i_dvld = 1'b0, i_rvld = 1'b0;
  logic [K*N-1:0] i_a = '0, o_b, prev_b = '0;
  logic [RR-1:0]  i_n_ref = '0;
  logic [RA-1:0]  i_n_and = '0;
  logic           o_dvld, o_busy;
  int             n_vec = 0, n_err = 0, m = 0;
  bit             zero_rand = 1'b0, b_upd = 1'b1;
  logic [K-1:0]   m_res = '0, m_sum = '0;
  always #5 clk_i = ~clk_i;
  sec_a2b_serial #(.K_WIDTH(K), .N_SHARES(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_dvld(i_dvld), .i_rvld(i_rvld), .i_a(i_a),
    .i_n_ref(i_n_ref), .i_n_and(i_n_and), .o_b(o_b), .o_dvld(o_dvld), .o_busy(o_busy)
  );
  function automatic logic [K-1:0] bxor(input logic [K*N-1:0] v);
    logic [K-1:0] r = '0;
    for (int i = 0; i < N; i++) r ^= v[i*K +: K];
    return r;
  endfunction
  function automatic logic [K-1:0] asum(input logic [K*N-1:0] v);
    logic [K-1:0] r = '0;
    for (int i = 0; i < N; i++) r += v[i*K +: K];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout, got no event expected one", nm);
  endtask
  // model: count enabled edges from accept; the result appears on the LAT-th
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m = 0;
      m_res = '0;
      b_upd = 1'b1;
    end else begin
      b_upd = 1'b0;
      if (i_rvld) begin
        if (m == LAT) m = 0;
        else if (m > 0) begin
          m++;
          if (m == LAT) begin
            m_res = m_sum;
            b_upd = 1'b1;
          end
        end else if (i_dvld) begin
          m = 1;
          m_sum = asum(i_a);
        end
      end
    end
  end
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("o_dvld", 32'(o_dvld), 32'(m == LAT));
      chk("o_busy", 32'(o_busy), 32'(m != 0));
      chk("xor_o_b", bxor(o_b), m_res);
      if (!b_upd) begin
        n_vec++;
        if (o_b !== prev_b) begin
          n_err++;
          $display("FAIL o_b_stable: got %h expected %h", o_b, prev_b);
        end
      end
    end
    prev_b = o_b;
  end
  always @(negedge clk_i) begin
    i_n_ref = zero_rand ? '0 : {$urandom, $urandom};
    i_n_and = zero_rand ? '0 : RA'($urandom);
  end
  task automatic wait_idle();
    i_rvld = 1'b1;
    i_dvld = 1'b0;
    for (int t = 0; t < 400 && m != 0; t++) @(negedge clk_i);
    if (m != 0) fail("wait_idle");
  endtask
  task automatic run(input logic [K-1:0] a0, a1, a2, input bit tog, input logic [K-1:0] exp, input string nm);
    int wall, en;
    bit seen;
    wait_idle();
    @(negedge clk_i);
    i_a = {a2, a1, a0};
    i_dvld = 1'b1;
    i_rvld = 1'b1;
    en = 1;
    wall = 0;
    seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk_i);
      i_dvld = 1'b0;
      wall++;
      if (o_dvld) begin
        seen = 1'b1;
        break;
      end
      i_rvld = tog ? (wall % 2 == 0) : 1'b1;
      en += 32'(i_rvld);
    end
    i_rvld = 1'b1;
    if (!seen) fail({nm, "_dvld"});
    else begin
      chk({nm, "_xor"}, bxor(o_b), exp);
      chk({nm, "_en_lat"}, en, LAT);
      if (!tog) chk({nm, "_lat"}, wall, LAT);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int rises, t1, t2, t3;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_dvld", 32'(o_dvld), 0);
    chk("rst_ob", 32'(|o_b), 0);
    rst_ni = 1'b1;
    for (int p = 0; p < 2; p++) begin
      run(32'h5, 32'h7, 32'hFFFFFFF4, p[0], 32'h0, p[0] ? "tog_5_7" : "v_5_7");
      run(32'hFFFFFFFF, 32'h1, 32'h0, p[0], 32'h0, p[0] ? "tog_carry" : "v_carry");
      run(32'h12345678, 32'h0, 32'h0, p[0], 32'h12345678, p[0] ? "tog_pass" : "v_pass");
    end
    zero_rand = 1'b1;
    run(32'h80000000, 32'h80000000, 32'h3, 1'b0, 32'h3, "zero_rand");
    zero_rand = 1'b0;
    run(32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, "pre_rst");
    wait_idle();
    @(negedge clk_i);
    i_a = {$urandom, $urandom, $urandom};
    i_dvld = 1'b1;
    repeat (45) begin
      @(negedge clk_i);
      i_dvld = 1'b0;
    end
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_dvld", 32'(o_dvld), 0);
    chk("midrst_ob", 32'(|o_b), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run(32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 32'h60, "post_rst");
    wait_idle();
    @(negedge clk_i);
    i_dvld = 1'b1;
    rises = 0;
    t1 = 0;
    t2 = 0;
    t3 = 0;
    for (int t = 1; t <= 210; t++) begin
      i_a = {$urandom, $urandom, $urandom};
      @(negedge clk_i);
      if (o_dvld) begin
        rises++;
        if (rises == 1) t1 = t;
        else if (rises == 2) t2 = t;
        else t3 = t;
      end
    end
    i_dvld = 1'b0;
    chk("held_count", rises, 3);
    chk("held_first", t1, LAT);
    chk("held_period", t2 - t1, LAT + 1);
    chk("held_period2", t3 - t2, LAT + 1);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk_i);
      i_rvld = ($urandom % 4) != 0;
      i_dvld = ($urandom % 3) == 0;
      i_a = {$urandom, $urandom, $urandom};
    end
    wait_idle();
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
